pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register with valid/ready handshake on both sides.
- Generalises the fixed-width fetch/decode latch with these additions:
  - independent payload and control field widths;
  - flush that turns the control field into a bubble (all-zero control, i.e. NOP);
  - a hazard-unit hold input;
  - an optional 2-entry skid buffer for full throughput under backpressure;
  - a saturating stall-cycle counter.
- Instantiated between any two pipeline stages: IF/ID, ID/EX, EX/MEM.

Parameters:
- PAYLOAD_W, 32: width of the data field that is not cleared on flush (e.g. PC+4).
- CTRL_W, 32: width of the control field that is zeroed on flush or reset (e.g. instruction word).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the stall_cnt counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents data.
- in_ready  out  1  stage can accept this cycle.
- in_payload  in  PAYLOAD_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- hold  in  1  hazard stall; blocks acceptance of new data.
- flush  in  1  discard all held entries.
- out_valid  out  1  stage holds valid data.
- out_ready  in  1  downstream accepts this cycle.
- out_payload  out  PAYLOAD_W  head payload.
- out_ctrl  out  CTRL_W  head control.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Definitions:
  - accept = in_valid & in_ready
  - out_fire = out_valid & out_ready
- in_ready:
  - SKID=1: in_ready = !skid_valid & !hold & !flush
  - SKID=0: in_ready = (!out_valid | out_ready) & !hold & !flush
- Reset (rst=1 at an edge): the following are all 0 after that edge:
  - out_valid, skid_valid, occupancy, stall_cnt;
  - out_ctrl and the skid control field;
  - out_payload and the skid payload.
- rst has priority over every other input; reset mid-transfer drops all entries.
- Flush (flush=1 at an edge, rst=0):
  - out_valid=0, skid_valid=0, occupancy=0.
  - Both control fields become 0.
  - Payload fields keep their value.
  - Any incoming data is dropped; in_ready is already 0, so no handshake is lost.
  - stall_cnt is not affected.
- Hold: forces in_ready=0 only. The downstream side still drains: out_fire still advances, so a bubble propagates downstream. Stored entries are never altered by hold.
- Latency: data accepted at edge N appears on out_* after edge N (1 cycle), when the stage is empty.
- Throughput: 1 transfer per cycle while out_ready=1.
- Ordering: strict FIFO order; nothing is duplicated or lost except by flush or rst.
- SKID=1 state machine (occupancy encodes the state):
  - EMPTY(0):
    - accept -> ONE; input loads main.
  - ONE(1):
    - accept & !out_fire -> FULL; input loads skid.
    - accept & out_fire -> ONE; input loads main.
    - !accept & out_fire -> EMPTY.
    - otherwise stay in ONE.
  - FULL(2):
    - in_ready=0.
    - out_fire -> ONE; skid moves to main.
    - otherwise stay in FULL.
- SKID=0:
  - The skid entry does not exist; occupancy is 0 or 1.
  - accept loads main and sets out_valid.
  - out_fire & !accept clears out_valid.
- out_payload and out_ctrl come directly from the main register (no combinational path from the inputs). Their values while out_valid=0 are the last held or cleared contents.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Holds at 2^CNT_W-1.
  - Cleared only by rst.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 and in_ctrl=32'hFFFFFFFF -> out_valid=0, out_ctrl=0, out_payload=0, occupancy=0, stall_cnt=0; in_ready=1 on the first cycle after rst drops.
- Streaming: with out_ready=1, send ctrl 1..8 on consecutive cycles -> out_ctrl shows 1..8 one cycle later, out_valid continuously 1, no gaps.
- Backpressure (SKID=1): send 0xA, 0xB, 0xC with out_ready=0 -> occupancy goes 1 then 2 and in_ready drops; 0xC is held off. Raise out_ready -> output order is 0xA, 0xB, 0xC, nothing lost.
- Flush when FULL: payload 0x100 in main, 0x104 in skid, pulse flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=0, out_payload=0x100, and the incoming item is never output.
- Hold: hold=1 for 3 cycles with one item held and out_ready=1 -> item drains, out_valid=0 for the remaining hold cycles, in_ready=0 throughout; normal accept resumes when hold drops.
- Counter saturation: CNT_W=3, out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt reads 1..7 then stays at 7; rst returns it to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready on both sides, bubble-inserting flush,
// hazard hold, optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 32,
  parameter int CTRL_W    = 32,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and a presented item stays until it transfers.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state, state_nxt;
  logic [PAYLOAD_W-1:0] main_payload, skid_payload;
  logic [CTRL_W-1:0]    main_ctrl, skid_ctrl;
  logic                 skid_valid;
  logic                 accept, out_fire;
  logic                 load_main, load_skid, move_skid;

  assign out_valid  = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign occupancy  = state;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !skid_valid && !hold && !flush;
    end else begin : g_noskid
      // skid_valid is constantly 0 here; kept in the term so both variants share logic
      assign in_ready = (!out_valid || out_ready) && !skid_valid && !hold && !flush;
    end
  endgenerate

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && !out_fire && (SKID != 0)) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (accept) begin
          load_main = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_nxt = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      main_payload <= '0;
      main_ctrl    <= '0;
      skid_payload <= '0;
      skid_ctrl    <= '0;
    end else if (flush) begin
      // Payloads are deliberately kept; only control is zeroed to form a NOP bubble
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_payload <= in_payload;
        main_ctrl    <= in_ctrl;
      end else if (move_skid) begin
        main_payload <= skid_payload;
        main_ctrl    <= skid_ctrl;
      end
      if (load_skid) begin
        skid_payload <= in_payload;
        skid_ctrl    <= in_ctrl;
      end
    end
  end

  assign out_payload = main_payload;
  assign out_ctrl    = main_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid variant with a 3-bit stall counter,
// plus a narrow single-register variant.
module tb_pipe_stage_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // skid variant signals
  logic        rst, in_valid, in_ready, hold, flush, out_valid, out_ready;
  logic [31:0] in_payload, out_payload, in_ctrl, out_ctrl;
  logic [1:0]  occupancy;
  logic [2:0]  stall_cnt;

  // single-register variant signals
  logic       rst0, in_valid0, in_ready0, hold0, flush0, out_valid0, out_ready0;
  logic [7:0] in_payload0, out_payload0, in_ctrl0, out_ctrl0;
  logic [1:0] occupancy0;
  logic [15:0] stall_cnt0;

  pipe_stage_reg #(.PAYLOAD_W(32), .CTRL_W(32), .SKID(1), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_ctrl(in_ctrl), .hold(hold), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.PAYLOAD_W(8), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_payload(in_payload0), .in_ctrl(in_ctrl0), .hold(hold0), .flush(flush0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_payload(out_payload0),
    .out_ctrl(out_ctrl0), .occupancy(occupancy0), .stall_cnt(stall_cnt0)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the output side, model the input side, then advance past the edge.
  task automatic tick();
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_item", out_ctrl, 64'hDEAD);
      else check("sb_order", out_ctrl, exp_q.pop_front());
    end
    if (flush || rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(in_ctrl);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] c, input logic [31:0] p);
    in_valid   = v;
    in_ctrl    = c;
    in_payload = p;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rst0 = 1'b1; in_valid0 = 1'b0; in_ctrl0 = 8'h0; in_payload0 = 8'h0;
    hold0 = 1'b0; flush0 = 1'b0; out_ready0 = 1'b0;

    // reset
    @(posedge clk); #1;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_payload", out_payload, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("rst_in_ready", in_ready, 1);

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 32'(i * 4));
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_ctrl", out_ctrl, 64'(i));
      check("stream_payload", out_payload, 64'(i * 4));
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_occ", occupancy, 0);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h200);
    tick();
    check("bp_occ_1", occupancy, 1);
    drive(1'b1, 32'hB, 32'h204);
    #1;
    check("bp_ready_one", in_ready, 1);
    tick();
    check("bp_occ_2", occupancy, 2);
    check("bp_head_a", out_ctrl, 32'hA);
    drive(1'b1, 32'hC, 32'h208);
    #1;
    check("bp_ready_full", in_ready, 0);
    tick();
    check("bp_still_full", occupancy, 2);
    out_ready = 1'b1;
    tick();
    check("bp_head_b", out_ctrl, 32'hB);
    check("bp_occ_after_pop", occupancy, 1);
    tick();
    check("bp_head_c", out_ctrl, 32'hC);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("bp_drained", occupancy, 0);
    check("bp_nothing_lost", exp_q.size(), 0);
    check("bp_stall_cnt", stall_cnt, 2);

    // flush when full
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h100);
    tick();
    drive(1'b1, 32'h22, 32'h104);
    tick();
    check("fl_occ_full", occupancy, 2);
    drive(1'b1, 32'h33, 32'h108);
    flush = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_out_valid", out_valid, 0);
    check("fl_occ", occupancy, 0);
    check("fl_out_ctrl", out_ctrl, 0);
    check("fl_out_payload", out_payload, 32'h100);
    check("fl_stall_cnt", stall_cnt, 4);
    out_ready = 1'b1;
    tick();
    tick();
    check("fl_no_ghost", out_valid, 0);

    // hold
    drive(1'b1, 32'h44, 32'h300);
    tick();
    check("hold_loaded", out_ctrl, 32'h44);
    drive(1'b1, 32'h55, 32'h304);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_in_ready", in_ready, 0);
      tick();
      check("hold_drained", out_valid, 0);
    end
    hold = 1'b0;
    #1;
    check("hold_release_ready", in_ready, 1);
    tick();
    check("hold_resume_valid", out_valid, 1);
    check("hold_resume_ctrl", out_ctrl, 32'h55);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // counter saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_rst_cnt", stall_cnt, 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h66, 32'h400);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("sat_cnt_start", stall_cnt, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("sat_cnt", stall_cnt, (k < 7) ? 64'(k) : 64'd7);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_cnt_cleared", stall_cnt, 0);
    check("sat_rst_valid", out_valid, 0);

    // single-register variant: in_ready follows out_ready combinationally
    rst0 = 1'b0;
    in_valid0 = 1'b1; in_ctrl0 = 8'h5A; in_payload0 = 8'h10;
    #1;
    check("s0_ready_empty", in_ready0, 1);
    @(posedge clk); #1;
    check("s0_occ_1", occupancy0, 1);
    check("s0_ctrl_x", out_ctrl0, 8'h5A);
    in_ctrl0 = 8'hA5; in_payload0 = 8'h20;
    #1;
    check("s0_ready_blocked", in_ready0, 0);
    @(posedge clk); #1;
    check("s0_held_x", out_ctrl0, 8'h5A);
    check("s0_stall", stall_cnt0, 1);
    out_ready0 = 1'b1;
    #1;
    check("s0_ready_pass", in_ready0, 1);
    @(posedge clk); #1;
    check("s0_ctrl_y", out_ctrl0, 8'hA5);
    check("s0_payload_y", out_payload0, 8'h20);
    check("s0_occ_still_1", occupancy0, 1);
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    check("s0_drained", out_valid0, 0);
    check("s0_occ_0", occupancy0, 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
